data_mem_responder: RTL and testbench

//  Word-addressed data-memory responder for the MIPS core's data port (daddr/dout/wr).

---
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-addressed 32-bit data memory behind a req/ack handshake.
//               It has byte-lane write enables and a fixed number of wait
//               states, so core stall logic can be run against slow memory.
//               This module owns the RAM array.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W       word-address width; depth = 2**ADDR_W words
//   WAIT_STATES  extra cycles between request capture and ack (0..15)
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   req    in   request valid; addr/wr/wdata stable until ack
//   addr   in   word address (ADDR_W)
//   wr     in   byte write enables, wr[i] -> bits 8i+7:8i; 0000 = read
//   wdata  in   write data (32)
//   rdata  out  read data (pre-write word), valid while ack=1
//   ack    out  one-cycle completion strobe
//   busy   out  high while a captured request waits for its ack
// Optional build macro
//   DMEM_TAP_EN  adds tap0/tap1/tap2 = mem[0]/mem[1]/mem[2] (combinational)
// ============================================================================
module data_mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              busy
`ifdef DMEM_TAP_EN
    ,
    output logic [31:0]       tap0,
    output logic [31:0]       tap1,
    output logic [31:0]       tap2
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // The counter is preloaded with WAIT_STATES-1 because the last WAIT
    // cycle, when cnt==0, is itself one of the wait states.
    localparam logic [3:0] C_WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          wr_q, wr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         mem [DEPTH];

    // Access that commits on this edge (the edge that enters RESP)
    logic                commit_en;
    logic [ADDR_W-1:0]   commit_addr;
    logic [3:0]          commit_wr;
    logic [31:0]         commit_wdata;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        commit_en    = 1'b0;
        commit_addr  = addr_q;
        commit_wr    = wr_q;
        commit_wdata = wdata_q;

        case (state_q)
            // RESP accepts a new request exactly like IDLE (back-to-back)
            ST_IDLE, ST_RESP: begin
                if (req) begin
                    addr_d  = addr;
                    wr_d    = wr;
                    wdata_d = wdata;
                    if (WAIT_STATES == 0) begin
                        // Capture and commit share one edge, so the request
                        // ports are used directly; the captured copy is not
                        // available yet.
                        state_d      = ST_RESP;
                        commit_en    = 1'b1;
                        commit_addr  = addr;
                        commit_wr    = wr;
                        commit_wdata = wdata;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = C_WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d   = ST_RESP;
                    commit_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read the pre-write word. Read-during-write returns the old data.
        rdata_d = commit_en ? mem[commit_addr] : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wr_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The array is not reset. Writes are blocked while rst is high, so a
    // request that reset aborts never reaches the array.
    always_ff @(posedge clk) begin
        if (commit_en && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (commit_wr[i]) begin
                    mem[commit_addr][8*i +: 8] <= commit_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign ack   = (state_q == ST_RESP);
    assign busy  = (state_q == ST_WAIT);

`ifdef DMEM_TAP_EN
    assign tap0 = mem[0];
    assign tap1 = mem[1];
    assign tap2 = mem[2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard bench for data_mem_responder. Two instances are
//               used: one with WAIT_STATES=0 and one with WAIT_STATES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    typedef struct packed {
        logic        chk;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0, rst3;
    logic        req0, req3;
    logic [7:0]  addr0, addr3;
    logic [3:0]  wr0, wr3;
    logic [31:0] wdata0, wdata3;
    logic [31:0] rdata0, rdata3;
    logic        ack0, ack3, busy0, busy3;
`ifdef DMEM_TAP_EN
    logic [31:0] t0a, t0b, t0c, t3a, t3b, t3c;
`endif

    exp_t q0[$];
    exp_t q3[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst0), .req(req0), .addr(addr0), .wr(wr0),
        .wdata(wdata0), .rdata(rdata0), .ack(ack0), .busy(busy0)
`ifdef DMEM_TAP_EN
        , .tap0(t0a), .tap1(t0b), .tap2(t0c)
`endif
    );

    data_mem_responder #(.ADDR_W(8), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst3), .req(req3), .addr(addr3), .wr(wr3),
        .wdata(wdata3), .rdata(rdata3), .ack(ack3), .busy(busy3)
`ifdef DMEM_TAP_EN
        , .tap0(t3a), .tap1(t3b), .tap2(t3c)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation for every ack the DUT presents
    always @(negedge clk) begin
        if (ack0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (e.chk) check("dut0 rdata", rdata0, e.val);
            end
        end
    end

    always @(negedge clk) begin
        if (ack3 === 1'b1) begin
            if (q3.size() == 0) begin
                check("dut3 unexpected ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                if (e.chk) check("dut3 rdata", rdata3, e.val);
            end
        end
    end

    // Single access on the zero-wait instance: ack in the cycle after capture
    task automatic acc0(input logic [7:0] a, input logic [3:0] w, input logic [31:0] d,
                        input logic c, input logic [31:0] e);
        q0.push_back('{chk: c, val: e});
        req0 = 1'b1; addr0 = a; wr0 = w; wdata0 = d;
        @(posedge clk); #1;
        check("dut0 ack after capture", {31'd0, ack0}, 32'd1);
        req0 = 1'b0; wr0 = 4'h0;
        @(posedge clk); #1;
        check("dut0 ack one cycle", {31'd0, ack0}, 32'd0);
    endtask

    // Single access on the 3-wait instance: busy 3 cycles, then ack for 1 cycle
    task automatic acc3(input logic [7:0] a, input logic [3:0] w, input logic [31:0] d,
                        input logic c, input logic [31:0] e);
        q3.push_back('{chk: c, val: e});
        req3 = 1'b1; addr3 = a; wr3 = w; wdata3 = d;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("dut3 busy/ack in wait", {30'd0, busy3, ack3}, 32'h2);
        end
        @(posedge clk); #1;
        check("dut3 busy/ack at resp", {30'd0, busy3, ack3}, 32'h1);
        req3 = 1'b0; wr3 = 4'h0;
        @(posedge clk); #1;
        check("dut3 busy/ack after resp", {30'd0, busy3, ack3}, 32'h0);
    endtask

    initial begin
        rst0 = 1'b1; rst3 = 1'b1;
        req0 = 1'b0; addr0 = 8'h0; wr0 = 4'h0; wdata0 = 32'h0;
        req3 = 1'b0; addr3 = 8'h0; wr3 = 4'h0; wdata3 = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst0 = 1'b0; rst3 = 1'b0;

        // Reset state
        check("dut0 reset ack/busy", {30'd0, busy0, ack0}, 32'h0);
        check("dut0 reset rdata", rdata0, 32'h0);
        check("dut3 reset ack/busy", {30'd0, busy3, ack3}, 32'h0);

        // Full-word write then read-back
        acc0(8'h05, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
        acc0(8'h05, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF);

        // Byte lanes: lanes 0 and 2 take the new data
        acc0(8'h10, 4'hF, 32'h11223344, 1'b0, 32'h0);
        acc0(8'h10, 4'b0101, 32'hAABBCCDD, 1'b1, 32'h11223344);
        acc0(8'h10, 4'h0, 32'h0, 1'b1, 32'h11BB33DD);

        // Preload 0..3, then hold req for four back-to-back reads
        for (int i = 0; i < 4; i++) acc0(8'(i), 4'hF, 32'(i), 1'b0, 32'h0);
        req0 = 1'b1; wr0 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            addr0 = 8'(i);
            q0.push_back('{chk: 1'b1, val: 32'(i)});
            @(posedge clk); #1;
            check("dut0 back-to-back ack", {31'd0, ack0}, 32'd1);
        end
        req0 = 1'b0;
        @(posedge clk); #1;
        check("dut0 ack drops after burst", {31'd0, ack0}, 32'd0);

        // Read-during-write returns the old word
        acc0(8'h20, 4'hF, 32'h0, 1'b0, 32'h0);
        acc0(8'h20, 4'hF, 32'hFFFF0000, 1'b1, 32'h0);
        acc0(8'h20, 4'h0, 32'h0, 1'b1, 32'hFFFF0000);

`ifdef DMEM_TAP_EN
        check("tap1 preload", t0b, 32'h1);
        q0.push_back('{chk: 1'b1, val: 32'h1});
        req0 = 1'b1; addr0 = 8'h01; wr0 = 4'hF; wdata0 = 32'h5A5A1234;
        @(posedge clk); #1;
        check("tap1 after write", t0b, 32'h5A5A1234);
        check("tap2 unchanged", t0c, 32'h2);
        req0 = 1'b0; wr0 = 4'h0;
        @(posedge clk); #1;
`endif

        // Wait states: write, then read back with busy/ack timing
        acc3(8'h07, 4'hF, 32'h00000077, 1'b0, 32'h0);
        acc3(8'h07, 4'h0, 32'h0, 1'b1, 32'h00000077);

        // Reset in the middle of WAIT aborts the write
        req3 = 1'b1; addr3 = 8'h07; wr3 = 4'hF; wdata3 = 32'h00000BAD;
        @(posedge clk); #1;
        check("dut3 busy before reset", {31'd0, busy3}, 32'd1);
        #2 rst3 = 1'b1;
        #1;
        check("dut3 reset mid-wait", {30'd0, busy3, ack3}, 32'h0);
        req3 = 1'b0; wr3 = 4'h0;
        @(posedge clk); #1;
        check("dut3 no ack under reset", {30'd0, busy3, ack3}, 32'h0);
        rst3 = 1'b0;
        acc3(8'h07, 4'h0, 32'h0, 1'b1, 32'h00000077);

        repeat (3) @(posedge clk);
        #1;
        check("dut0 outstanding expectations", 32'(q0.size()), 32'd0);
        check("dut3 outstanding expectations", 32'(q3.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
